// File: rtl/fadd_pkg.sv
// Shared types and constants for the FP32 adder scheduler.
package fadd_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned TAG_IDX_W = 3;

  localparam logic [FP_W-1:0] ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] ZERO = 32'h0000_0000;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // In-flight op tracker; index sized for the largest supported NREQ.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] index;
  } tag_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin grant: search starts just after the last winner.
module rr_arb
  import fadd_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic        w_found;
  int unsigned w_pos;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_pos = (32'(ptr) + k) % NREQ;
      if (!w_found && req[IDX_W'(w_pos)]) begin
        grant[IDX_W'(w_pos)] = 1'b1;
        w_found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_sched.sv
// Round-robin scheduler sharing one fixed-latency FP32 adder among NREQ
// requesters; a tag pipeline routes each sum back to its issuer.
module fadd_sched
  import fadd_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 add_en,
  output logic [FP_W-1:0]      add_a,
  output logic [FP_W-1:0]      add_b,
  input  logic [FP_W-1:0]      add_sum,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]      rsp_data,
  output logic                 busy
);

  localparam int unsigned IDX_W = idx_w(NREQ);

  logic [IDX_W-1:0] r_ptr;
  logic             r_add_en;
  logic [FP_W-1:0]  r_add_a;
  logic [FP_W-1:0]  r_add_b;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [FP_W-1:0]  r_rsp_data;
  tag_t             r_tag [LAT+1];

  logic [NREQ-1:0]  w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_hs;
  logic             w_tag_any;
  logic [FP_W-1:0]  w_a [NREQ];
  logic [FP_W-1:0]  w_b [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_a[g] = req_a[g*FP_W +: FP_W];
    assign w_b[g] = req_b[g*FP_W +: FP_W];
  end

  rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // One-hot grant to index; grant already implies the matching valid.
  always_comb begin
    w_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_grant[k]) w_idx = IDX_W'(k);
    end
  end

  assign w_hs = |w_grant;

  always_comb begin
    w_tag_any = 1'b0;
    for (int unsigned k = 0; k <= LAT; k++) begin
      w_tag_any = w_tag_any | r_tag[k].valid;
    end
  end

  // Issue side: pointer and adder operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= IDX_W'(NREQ - 1);
      r_add_en <= 1'b0;
      r_add_a  <= ZERO;
      r_add_b  <= ZERO;
    end else begin
      r_add_en <= w_hs;
      if (w_hs) begin
        r_ptr   <= w_idx;
        r_add_a <= w_a[w_idx];
        r_add_b <= w_b[w_idx];
      end
    end
  end

  // Tag pipeline shifts every cycle; last stage lines up with add_sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0].valid <= w_hs;
      r_tag[0].index <= TAG_IDX_W'(w_idx);
      for (int unsigned k = 1; k <= LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Retire side: capture the sum and strobe the originating requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= ZERO;
    end else if (r_tag[LAT].valid) begin
      r_rsp_valid <= NREQ'(1) << r_tag[LAT].index;
      r_rsp_data  <= add_sum;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign req_ready = rst_n ? w_grant : '0;
  assign add_en    = r_add_en;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = w_tag_any | r_add_en | (|req_valid);

endmodule

// File: tb/tb_fadd_sched.sv
// Directed bench for fadd_sched with a behavioural FP32 adder and an in-order response scoreboard.
module tb_fadd_sched;
  import fadd_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 add_en;
  logic [FP_W-1:0]      add_a;
  logic [FP_W-1:0]      add_b;
  logic [FP_W-1:0]      add_sum;
  logic [NREQ-1:0]      rsp_valid;
  logic [FP_W-1:0]      rsp_data;
  logic                 busy;

  logic [FP_W-1:0] a_in    [NREQ];
  logic [FP_W-1:0] b_in    [NREQ];
  logic [FP_W-1:0] exp_sum [NREQ];

  typedef struct {
    int              due;
    logic [NREQ-1:0] oh;
    logic [FP_W-1:0] data;
  } exp_t;

  exp_t q [$];
  int   cyc   = 0;
  int   n_err = 0;
  int   n_chk = 0;

  fadd_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_a[k*FP_W +: FP_W] = a_in[k];
      req_b[k*FP_W +: FP_W] = b_in[k];
    end
  end

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Behavioural adder: result appears LAT cycles after add_en.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= r2f(f2r(add_a) + f2r(add_b));
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_sum = pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Response monitor: exactly the scheduled strobes, nothing else.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due < cyc) check("rsp_late", 32'(cyc), 32'(e.due));
      check("rsp_valid", 32'(rsp_valid), 32'(e.oh));
      check("rsp_data", rsp_data, e.data);
    end else begin
      check("rsp_idle", 32'(rsp_valid), 32'd0);
    end
  end

  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] g);
    @(posedge clk);
    #1 req_valid = v;
    @(negedge clk);
    check("grant", 32'(req_ready), 32'(g));
    for (int k = 0; k < NREQ; k++)
      if (g[k]) q.push_back('{due: cyc + LAT + 2, oh: g, data: exp_sum[k]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    for (int k = 0; k < NREQ; k++) begin
      a_in[k] = ZERO; b_in[k] = ZERO; exp_sum[k] = ZERO;
    end
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_add_en", 32'(add_en), 32'd0);
    check("rst_add_a", add_a, ZERO);
    check("rst_rsp_data", rsp_data, ZERO);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single op on requester 1: 1.0 + 2.0
    a_in[1] = ONE; b_in[1] = 32'h4000_0000; exp_sum[1] = 32'h4040_0000;
    drive(4'b0010, 4'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("t1_add_en", 32'(add_en), 32'd1);
    check("t1_add_a", add_a, ONE);
    check("t1_add_b", add_b, 32'h4000_0000);
    drive('0, '0);
    check("t1_add_en_drop", 32'(add_en), 32'd0);
    idle(5);

    // Lone requester 3 streams back-to-back: 4.0 + 1.0
    a_in[3] = 32'h4080_0000; b_in[3] = ONE; exp_sum[3] = 32'h40A0_0000;
    for (int i = 0; i < 5; i++) drive(4'b1000, 4'b1000);
    idle(6);

    // All valid: strict rotation 0..3 twice
    a_in[0] = 32'h3F80_0000; a_in[1] = 32'h4000_0000;
    a_in[2] = 32'h4040_0000; a_in[3] = 32'h4080_0000;
    for (int k = 0; k < NREQ; k++) b_in[k] = ONE;
    exp_sum[0] = 32'h4000_0000; exp_sum[1] = 32'h4040_0000;
    exp_sum[2] = 32'h4080_0000; exp_sum[3] = 32'h40A0_0000;
    for (int i = 0; i < 8; i++) drive('1, 4'(1 << (i % 4)));
    idle(6);

    // Skip: after granting 0, only 1 and 3 valid
    drive(4'b0001, 4'b0001);
    drive(4'b1010, 4'b0010);
    drive(4'b1010, 4'b1000);
    drive(4'b1010, 4'b0010);
    drive(4'b1010, 4'b1000);
    idle(6);

    // Opposite signs: 1 + -1 = 0, -3 + 1 = -2
    a_in[0] = 32'h3F80_0000; b_in[0] = 32'hBF80_0000; exp_sum[0] = 32'h0000_0000;
    a_in[2] = 32'hC040_0000; b_in[2] = 32'h3F80_0000; exp_sum[2] = 32'hC000_0000;
    drive(4'b0001, 4'b0001);
    drive(4'b0100, 4'b0100);
    idle(6);

    // Reset while the third op's add_en is high
    drive(4'b0001, 4'b0001);
    drive(4'b0010, 4'b0010);
    drive(4'b0100, 4'b0100);
    @(posedge clk);
    #1 req_valid = '1;
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    check("mid_rst_add_en", 32'(add_en), 32'd0);
    check("mid_rst_add_a", add_a, ZERO);
    check("mid_rst_add_b", add_b, ZERO);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", rsp_data, ZERO);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    idle(10);
    drive('1, 4'b0001);
    idle(7);

    check("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
